multiexp_arith_arb: RTL and testbench

- Round-robin arbiter that shares one Fp arithmetic pipeline (mul/add/sub) between NUM_REQ multiexp point-add/double cores.
- Sits between the multiexp cores and the shared arithmetic unit inside the multiexp top level.
- Tags each granted request with the requester ID, and routes each result back by that tag.
- Bounds in-flight operations per requester with credit counters, so the result buffers in each core cannot overflow.

---
 rtl/multiexp_arith_arb.sv | 168 ++++++++++++++++
 tb/tb_multiexp_arith_arb.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/multiexp_arith_arb.sv
// Round-robin arbiter sharing one Fp mul/add/sub pipeline between NUM_REQ multiexp cores.
// Results are routed back by tag, with per-requester credits. Define MULTIEXP_ARB_STATS_EN for per-requester grant counters.
module multiexp_arith_arb #(
  parameter int NUM_REQ   = 2,
  parameter int DAT_BITS  = 512,
  parameter int RES_BITS  = 256,
  parameter int CTL_BITS  = 8,
  parameter int MAX_OUTST = 4,
  parameter int ID_BITS   = (NUM_REQ > 2) ? $clog2(NUM_REQ) : 1
) (
  input  logic                         i_clk,
  input  logic                         i_rst,
  input  logic [NUM_REQ-1:0]           i_req_val,
  output logic [NUM_REQ-1:0]           o_req_rdy,
  input  logic [NUM_REQ*DAT_BITS-1:0]  i_req_dat,
  input  logic [NUM_REQ*CTL_BITS-1:0]  i_req_ctl,
  output logic                         o_arb_val,
  input  logic                         i_arb_rdy,
  output logic [DAT_BITS-1:0]          o_arb_dat,
  output logic [CTL_BITS+ID_BITS-1:0]  o_arb_ctl,
  input  logic                         i_res_val,
  output logic                         o_res_rdy,
  input  logic [RES_BITS-1:0]          i_res_dat,
  input  logic [CTL_BITS+ID_BITS-1:0]  i_res_ctl,
  output logic [NUM_REQ-1:0]           o_res_val,
  input  logic [NUM_REQ-1:0]           i_res_rdy,
  output logic [RES_BITS-1:0]          o_res_dat,
  output logic [CTL_BITS-1:0]          o_res_ctl,
  output logic                         o_err,
  output logic [NUM_REQ*32-1:0]        o_gnt_cnt
);

  localparam int CNT_W = 4;
  localparam logic [CNT_W-1:0]   MAX_C   = CNT_W'(MAX_OUTST);
  localparam logic [CNT_W-1:0]   CNT_ONE = CNT_W'(1);
  localparam logic [ID_BITS-1:0] LAST_ID = ID_BITS'(NUM_REQ - 1);

  logic [CNT_W-1:0]            r_cnt [NUM_REQ];
  logic [ID_BITS-1:0]          r_ptr;
  logic                        r_arb_val;
  logic [DAT_BITS-1:0]         r_arb_dat;
  logic [CTL_BITS+ID_BITS-1:0] r_arb_ctl;
  logic                        r_err;

  logic                        w_free;
  logic [NUM_REQ-1:0]          w_elig;
  logic                        w_hi_any, w_lo_any, w_any;
  logic [ID_BITS-1:0]          w_hi_id, w_lo_id, w_win;
  logic [DAT_BITS-1:0]         w_sel_dat;
  logic [CTL_BITS-1:0]         w_sel_ctl;
  logic [ID_BITS-1:0]          w_tag;
  logic                        w_tag_ok, w_sel_rdy, w_cnt_zero, w_res_fire, w_err_set;

  assign w_free = !r_arb_val || i_arb_rdy;

  // Winner is the first eligible index above the pointer, else the first eligible overall.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
    w_hi_any  = 1'b0;
    w_lo_any  = 1'b0;
    w_hi_id   = '0;
    w_lo_id   = '0;
    w_sel_dat = '0;
    w_sel_ctl = '0;
    w_elig    = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      w_elig[k] = i_req_val[k] && (r_cnt[k] < MAX_C);
      if (w_elig[k] && !w_hi_any && (ID_BITS'(k) > r_ptr)) begin
        w_hi_any = 1'b1;
        w_hi_id  = ID_BITS'(k);
      end
      if (w_elig[k] && !w_lo_any) begin
        w_lo_any = 1'b1;
        w_lo_id  = ID_BITS'(k);
      end
    end
    w_any = w_hi_any || w_lo_any;
    w_win = w_hi_any ? w_hi_id : w_lo_id;
    o_req_rdy = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      o_req_rdy[k] = w_free && w_any && (w_win == ID_BITS'(k));
      if (w_win == ID_BITS'(k)) begin
        w_sel_dat = i_req_dat[k*DAT_BITS +: DAT_BITS];
        w_sel_ctl = i_req_ctl[k*CTL_BITS +: CTL_BITS];
      end
    end
  end

  // Result routing is purely combinational; an unknown tag is swallowed.
  always_comb begin
    w_tag      = i_res_ctl[CTL_BITS +: ID_BITS];
    w_tag_ok   = 1'b0;
    w_sel_rdy  = 1'b0;
    w_cnt_zero = 1'b0;
    o_res_val  = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (w_tag == ID_BITS'(k)) begin
        w_tag_ok     = 1'b1;
        w_sel_rdy    = i_res_rdy[k];
        w_cnt_zero   = (r_cnt[k] == '0);
        o_res_val[k] = i_res_val;
      end
    end
    o_res_rdy  = w_tag_ok ? w_sel_rdy : 1'b1;
    w_res_fire = i_res_val && w_tag_ok && w_sel_rdy;
    w_err_set  = (i_res_val && !w_tag_ok) || (w_res_fire && w_cnt_zero);
  end

  assign o_res_dat = i_res_dat;
  assign o_res_ctl = i_res_ctl[CTL_BITS-1:0];

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      r_arb_val <= 1'b0;
      // NOTE: the wide payload registers are reset as well, since o_arb_dat/o_arb_ctl must read 0 out of reset.
      r_arb_dat <= '0;
      r_arb_ctl <= '0;
      r_ptr     <= LAST_ID;
      r_err     <= 1'b0;
      for (int k = 0; k < NUM_REQ; k++) r_cnt[k] <= '0;
    end else begin
      // NOTE: state is updated with non-blocking assignments so every flop samples pre-edge values.
      if (w_free) begin
        r_arb_val <= w_any;
        if (w_any) begin
          r_arb_dat <= w_sel_dat;
          r_arb_ctl <= {w_win, w_sel_ctl};
          r_ptr     <= w_win;
        end
      end
      if (w_err_set) r_err <= 1'b1;
      for (int k = 0; k < NUM_REQ; k++) begin
        // A grant and a return to the same requester in one cycle cancel out.
        if (o_req_rdy[k] && !(w_res_fire && (w_tag == ID_BITS'(k)) && (r_cnt[k] != '0))) begin
          if (r_cnt[k] < MAX_C) r_cnt[k] <= r_cnt[k] + CNT_ONE;
        end else if (!o_req_rdy[k] && w_res_fire && (w_tag == ID_BITS'(k)) && (r_cnt[k] != '0)) begin
          r_cnt[k] <= r_cnt[k] - CNT_ONE;
        end
      end
    end
  end

  assign o_arb_val = r_arb_val;
  assign o_arb_dat = r_arb_dat;
  assign o_arb_ctl = r_arb_ctl;
  assign o_err     = r_err;

`ifdef MULTIEXP_ARB_STATS_EN
  logic [31:0] r_gnt_cnt [NUM_REQ];

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      for (int k = 0; k < NUM_REQ; k++) r_gnt_cnt[k] <= '0;
    end else begin
      for (int k = 0; k < NUM_REQ; k++)
        if (o_req_rdy[k] && i_req_val[k]) r_gnt_cnt[k] <= r_gnt_cnt[k] + 32'd1;
    end
  end

  always_comb begin
    o_gnt_cnt = '0;
    for (int k = 0; k < NUM_REQ; k++) o_gnt_cnt[k*32 +: 32] = r_gnt_cnt[k];
  end
`else
  assign o_gnt_cnt = '0;
`endif

endmodule

// File: tb/tb_multiexp_arith_arb.sv
// Directed bench for multiexp_arith_arb: a 2-requester instance for arbitration/credits/routing,
// and a 3-requester instance for the bad-tag path.
module tb_multiexp_arith_arb;

  logic           clk = 1'b0;
  logic           rst_n;
  logic [1:0]     req_val, req_rdy;
  logic [1023:0]  req_dat;
  logic [15:0]    req_ctl;
  logic           arb_val, arb_rdy;
  logic [511:0]   arb_dat;
  logic [8:0]     arb_ctl;
  logic           res_val, res_rdy_o;
  logic [255:0]   res_dat, res_dat_o;
  logic [8:0]     res_ctl;
  logic [1:0]     res_val_o, res_rdy_i;
  logic [7:0]     res_ctl_o;
  logic           err;
  logic [63:0]    gnt_cnt;

  logic [2:0]     req_val3, req_rdy3, res_val3_o, res_rdy3_i;
  logic [1535:0]  req_dat3;
  logic [23:0]    req_ctl3;
  logic           arb_val3, arb_rdy3, res_val3, res_rdy3_o, err3;
  logic [511:0]   arb_dat3;
  logic [9:0]     arb_ctl3, res_ctl3;
  logic [255:0]   res_dat3, res_dat3_o;
  logic [7:0]     res_ctl3_o;
  logic [95:0]    gnt_cnt3;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  multiexp_arith_arb u_dut (
    .i_clk(clk), .i_rst(rst_n),
    .i_req_val(req_val), .o_req_rdy(req_rdy), .i_req_dat(req_dat), .i_req_ctl(req_ctl),
    .o_arb_val(arb_val), .i_arb_rdy(arb_rdy), .o_arb_dat(arb_dat), .o_arb_ctl(arb_ctl),
    .i_res_val(res_val), .o_res_rdy(res_rdy_o), .i_res_dat(res_dat), .i_res_ctl(res_ctl),
    .o_res_val(res_val_o), .i_res_rdy(res_rdy_i), .o_res_dat(res_dat_o), .o_res_ctl(res_ctl_o),
    .o_err(err), .o_gnt_cnt(gnt_cnt)
  );

  multiexp_arith_arb #(.NUM_REQ(3)) u_dut3 (
    .i_clk(clk), .i_rst(rst_n),
    .i_req_val(req_val3), .o_req_rdy(req_rdy3), .i_req_dat(req_dat3), .i_req_ctl(req_ctl3),
    .o_arb_val(arb_val3), .i_arb_rdy(arb_rdy3), .o_arb_dat(arb_dat3), .o_arb_ctl(arb_ctl3),
    .i_res_val(res_val3), .o_res_rdy(res_rdy3_o), .i_res_dat(res_dat3), .i_res_ctl(res_ctl3),
    .o_res_val(res_val3_o), .i_res_rdy(res_rdy3_i), .o_res_dat(res_dat3_o), .o_res_ctl(res_ctl3_o),
    .o_err(err3), .o_gnt_cnt(gnt_cnt3)
  );

  typedef struct {
    logic [1:0] req_val;
    logic       arb_rdy;
    logic       res_val;
    logic       res_tag;
    logic [7:0] res_ctl;
    logic [1:0] res_rdy;
    logic [1:0] e_req_rdy;
    logic       e_arb_val;
    logic       e_tag;
    logic [1:0] e_res_val;
    logic       e_res_rdy;
  } vec_t;

  vec_t vecs [20];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic vec_t mk(input logic [1:0] rv, input logic ar, input logic resv, input logic tag,
                              input logic [7:0] rctl, input logic [1:0] rr, input logic [1:0] erdy,
                              input logic eav, input logic etag, input logic [1:0] erv, input logic err_rdy);
    vec_t v;
    v.req_val = rv;   v.arb_rdy = ar;     v.res_val = resv; v.res_tag = tag;
    v.res_ctl = rctl; v.res_rdy = rr;     v.e_req_rdy = erdy;
    v.e_arb_val = eav; v.e_tag = etag;    v.e_res_val = erv; v.e_res_rdy = err_rdy;
    return v;
  endfunction

  // Requester payloads are fixed so the expected output follows from the tag alone.
  function automatic logic [8:0] exp_ctl(input logic tag);
    return {tag, (tag ? 8'h21 : 8'h10)};
  endfunction

  function automatic logic [63:0] exp_dat(input logic tag);
    return tag ? 64'hB1 : 64'hA0;
  endfunction

  initial begin
    // Alternating grants with returns 3 cycles later, then 5-cycle stall, then drain with routing backpressure.
    vecs[0]  = mk(2'b11, 1, 0, 0, 8'h00, 2'b11, 2'b01, 0, 0, 2'b00, 1);
    vecs[1]  = mk(2'b11, 1, 0, 0, 8'h00, 2'b11, 2'b10, 1, 0, 2'b00, 1);
    vecs[2]  = mk(2'b11, 1, 0, 0, 8'h00, 2'b11, 2'b01, 1, 1, 2'b00, 1);
    vecs[3]  = mk(2'b11, 1, 1, 0, 8'h33, 2'b11, 2'b10, 1, 0, 2'b01, 1);
    vecs[4]  = mk(2'b11, 1, 1, 1, 8'h44, 2'b11, 2'b01, 1, 1, 2'b10, 1);
    vecs[5]  = mk(2'b11, 1, 1, 0, 8'h55, 2'b11, 2'b10, 1, 0, 2'b01, 1);
    vecs[6]  = mk(2'b11, 1, 1, 1, 8'h66, 2'b11, 2'b01, 1, 1, 2'b10, 1);
    vecs[7]  = mk(2'b11, 1, 1, 0, 8'h77, 2'b11, 2'b10, 1, 0, 2'b01, 1);
    for (int i = 8; i < 13; i++)
      vecs[i] = mk(2'b11, 0, 0, 0, 8'h00, 2'b11, 2'b00, 1, 1, 2'b00, 1);
    vecs[13] = mk(2'b11, 1, 0, 0, 8'h00, 2'b11, 2'b01, 1, 1, 2'b00, 1);
    vecs[14] = mk(2'b00, 1, 1, 0, 8'h88, 2'b11, 2'b00, 1, 0, 2'b01, 1);
    vecs[15] = mk(2'b00, 1, 1, 0, 8'h99, 2'b11, 2'b00, 0, 0, 2'b01, 1);
    vecs[16] = mk(2'b00, 1, 1, 1, 8'hA5, 2'b01, 2'b00, 0, 0, 2'b10, 0);
    vecs[17] = mk(2'b00, 1, 1, 1, 8'hA5, 2'b01, 2'b00, 0, 0, 2'b10, 0);
    vecs[18] = mk(2'b00, 1, 1, 1, 8'hA5, 2'b11, 2'b00, 0, 0, 2'b10, 1);
    vecs[19] = mk(2'b00, 1, 1, 1, 8'hBB, 2'b11, 2'b00, 0, 0, 2'b10, 1);

    rst_n = 1'b0;
    req_val = '0; req_dat = {512'hB1, 512'hA0}; req_ctl = {8'h21, 8'h10};
    arb_rdy = 1'b0; res_val = 1'b0; res_dat = '0; res_ctl = '0; res_rdy_i = 2'b11;
    req_val3 = '0; req_dat3 = '0; req_ctl3 = '0; arb_rdy3 = 1'b1;
    res_val3 = 1'b0; res_dat3 = '0; res_ctl3 = '0; res_rdy3_i = 3'b111;

    #3;
    check("rst_arb_val", 64'(arb_val), 64'd0);
    check("rst_arb_dat", arb_dat[63:0], 64'd0);
    check("rst_arb_ctl", 64'(arb_ctl), 64'd0);
    check("rst_err", 64'(err), 64'd0);
    check("rst_gnt_cnt", gnt_cnt, 64'd0);
    #9 rst_n = 1'b1;
    step();

    for (int i = 0; i < 20; i++) begin
      req_val   = vecs[i].req_val;
      arb_rdy   = vecs[i].arb_rdy;
      res_val   = vecs[i].res_val;
      res_ctl   = {vecs[i].res_tag, vecs[i].res_ctl};
      res_rdy_i = vecs[i].res_rdy;
      res_dat   = 256'(i * 16 + 7);
      #1;
      check($sformatf("v%0d_req_rdy", i), 64'(req_rdy), 64'(vecs[i].e_req_rdy));
      check($sformatf("v%0d_arb_val", i), 64'(arb_val), 64'(vecs[i].e_arb_val));
      if (vecs[i].e_arb_val) begin
        check($sformatf("v%0d_arb_ctl", i), 64'(arb_ctl), 64'(exp_ctl(vecs[i].e_tag)));
        check($sformatf("v%0d_arb_dat", i), arb_dat[63:0], exp_dat(vecs[i].e_tag));
      end
      check($sformatf("v%0d_res_val", i), 64'(res_val_o), 64'(vecs[i].e_res_val));
      check($sformatf("v%0d_res_rdy", i), 64'(res_rdy_o), 64'(vecs[i].e_res_rdy));
      if (vecs[i].res_val) begin
        check($sformatf("v%0d_res_ctl", i), 64'(res_ctl_o), 64'(vecs[i].res_ctl));
        check($sformatf("v%0d_res_dat", i), res_dat_o[63:0], 64'(i * 16 + 7));
      end
      step();
    end
    res_val = 1'b0;

    // Credits: requester 0 alone gets exactly MAX_OUTST grants.
    req_val = 2'b01; arb_rdy = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      check($sformatf("cred_grant%0d", i), 64'(req_rdy), 64'b01);
      step();
    end
    #1;
    check("cred_full_rdy", 64'(req_rdy), 64'b00);
    check("cred_last_val", 64'(arb_val), 64'd1);
    step();
    check("cred_idle_val", 64'(arb_val), 64'd0);
    res_val = 1'b1; res_ctl = {1'b0, 8'hC0};
    #1;
    check("cred_ret_rdy", 64'(res_rdy_o), 64'd1);
    check("cred_ret_val", 64'(res_val_o), 64'b01);
    check("cred_ret_nogrant", 64'(req_rdy), 64'b00);
    step();
    #1;
    check("cred_fifth", 64'(req_rdy), 64'b01);
    step();
    res_val = 1'b0;
    #1;
    check("cred_same_cycle", 64'(req_rdy), 64'b01);
    step();
    #1;
    check("cred_full_again", 64'(req_rdy), 64'b00);
    req_val = 2'b00; res_val = 1'b1; res_ctl = {1'b0, 8'hC1};
    for (int i = 0; i < 4; i++) step();
    res_val = 1'b0;
    #1;
    check("no_err", 64'(err), 64'd0);

    // Bad tag on the 3-requester instance.
    req_val3 = 3'b001;
    step();
    req_val3 = 3'b000;
    check("bt_err_before", 64'(err3), 64'd0);
    res_val3 = 1'b1; res_ctl3 = {2'd3, 8'h5A}; res_rdy3_i = 3'b000;
    #1;
    check("bt_res_rdy", 64'(res_rdy3_o), 64'd1);
    check("bt_res_val", 64'(res_val3_o), 64'd0);
    step();
    check("bt_err_set", 64'(err3), 64'd1);
    res_ctl3 = {2'd0, 8'h3C}; res_rdy3_i = 3'b111;
    #1;
    check("bt_good_val", 64'(res_val3_o), 64'b001);
    check("bt_good_rdy", 64'(res_rdy3_o), 64'd1);
    check("bt_good_ctl", 64'(res_ctl3_o), 64'h3C);
    step();
    res_val3 = 1'b0;
    step();
    step();
    check("bt_err_held", 64'(err3), 64'd1);

    // Asynchronous reset in the middle of a burst.
    req_val = 2'b11; arb_rdy = 1'b1;
    step();
    step();
    check("burst_val", 64'(arb_val), 64'd1);
    #2 rst_n = 1'b0;
    #1;
    check("async_arb_val", 64'(arb_val), 64'd0);
    check("async_arb_ctl", 64'(arb_ctl), 64'd0);
    check("async_err3", 64'(err3), 64'd0);
    #2 rst_n = 1'b1;
    #1;
    check("post_rst_first", 64'(req_rdy), 64'b01);

    // Ten grants to requester 1, returning one result per cycle to keep credit available.
    req_val = 2'b10; res_ctl = {1'b1, 8'h00};
    #1;
    for (int i = 0; i < 10; i++) begin
      res_val = (i > 0);
      #1;
      check($sformatf("stat_grant%0d", i), 64'(req_rdy), 64'b10);
      step();
    end
    req_val = 2'b00; res_val = 1'b0;
    #1;
`ifdef MULTIEXP_ARB_STATS_EN
    check("stat_cnt1", 64'(gnt_cnt[63:32]), 64'd10);
`else
    check("stat_cnt1", 64'(gnt_cnt[63:32]), 64'd0);
`endif
    check("stat_cnt0", 64'(gnt_cnt[31:0]), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
